stream_demux_1_4: RTL and testbench
===================================

Name: stream_demux_1_4

Overview:
Registered 1-to-4 stream demultiplexer with valid/ready handshake on every port. It is the distribution-side counterpart of the 4:1 data muxes used in the combinational library. A single input word is routed to one of four output slots. The slot is chosen either by an explicit select or by an internal round-robin pointer. Each output slot is a one-entry register buffer, so the block sits between a single producer and four independent consumers.

Parameters:
W, 4, data width of the input word and of each output slot.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  producer presents a word.
in_ready  output  1  block can accept the word this cycle.
d  input  W  input data.
sel  input  2  target slot when rr_en=0.
rr_en  input  1  1: ignore sel and use the internal round-robin pointer.
out_valid  output  4  per-slot valid; bit k belongs to slot k.
out_data  output  4*W  packed slot data; slot k occupies bits [k*W +: W].
out_ready  input  4  per-slot consumer ready.

Behaviour:
- Reset: when rst=1 at a clock edge:
  - out_valid=4'b0000, all out_data=0, rr_ptr=0.
  - in_ready reads 1 in the first cycle after reset.
- Effective select: eff_sel = rr_en ? rr_ptr : sel. It is combinational.
- in_ready = !out_valid[eff_sel] || out_ready[eff_sel].
  - This path is combinational from out_ready, sel, rr_en and state.
  - Pass-through on a simultaneous drain is allowed.
- Accept: accept = in_valid && in_ready.
  - On accept, slot eff_sel loads d and sets valid.
  - The word is visible on out_data/out_valid the next cycle. Latency is 1 cycle.
- Drain rules for slot k:
  - out_valid[k] && out_ready[k] with no load into k: out_valid[k] clears.
  - out_data[k] holds its last value after it drains; it is not cleared.
  - Load and drain in the same cycle on slot k: out_valid[k] stays 1 and out_data[k] takes the new d.
- Slot independence:
  - Slots not addressed by eff_sel are unaffected by input activity.
  - Any subset of the four slots may be valid at the same time.
- Round-robin pointer rr_ptr (2 bits):
  - Increments by 1 on each accept while rr_en=1 and wraps 3 -> 0.
  - Holds when rr_en=0 or when there is no accept.
- Blocked round-robin slot:
  - In rr mode, if the pointed slot is full and its consumer is not ready, in_ready=0 and the pointer waits.
  - The block does not skip to a free slot.
- Select stability: sel and rr_en may change freely while in_valid=1 and there is no accept. Only the value at the accepting edge matters.
- Idle input: with in_valid=0, d and sel may be X. State, out_valid and out_data are unchanged apart from drains.
- Reset mid-operation: buffered words are discarded. The state after reset is identical to the reset state above.

Decomposition:
- Package stream_demux_pkg holds:
  - N_OUT=4 and SEL_W=2;
  - typedef sel_t (logic [SEL_W-1:0]);
  - a function next_rr(sel_t) implementing the wrap-around increment.
- Sub-module out_slot: the one-entry buffer.
  - Inputs: load, drain, d. Outputs: valid, data.
  - Instantiated four times, once per slot.
- The top level holds:
  - the eff_sel mux;
  - the in_ready mux;
  - decode of accept into the four load strobes;
  - the round-robin pointer.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release -> out_valid=0000, all out_data=0, in_ready=1; in_valid=0 with d=X leaves all outputs unchanged.
2. Directed fill: rr_en=0, out_ready=0000, accept d=a,b,c,d with sel=0,1,2,3 -> out_valid=1111 and slots hold a,b,c,d. Then in_valid=1 with sel=2 -> in_ready=0 and slot 2 keeps c.
3. Pass-through: slot 1 holds 7 with out_ready[1]=1; in_valid=1, sel=1, d=3 -> in_ready=1. The next cycle shows out_valid[1]=1 and slot 1 data=3; other slots are unchanged.
4. Round-robin: rr_en=1, sel held at 3, out_ready=1111, accept d=1,2,3,4,5 -> the words land in slots 0,1,2,3,0 and rr_ptr ends at 1.
5. Round-robin backpressure: rr_ptr=1, slot 1 full, out_ready[1]=0 -> in_ready=0 and rr_ptr stays 1. Raise out_ready[1] -> the accept proceeds and rr_ptr becomes 2.
6. Reset mid-operation: with all four slots valid and rr_ptr=2, pulse rst for one cycle -> out_valid=0000, out_data=0, rr_ptr=0. The next accept in rr mode lands in slot 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-4 stream demultiplexer.
// Slot count, select width and the round-robin wrap-around increment.
package stream_demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Wraps 3 -> 0 naturally through the 2-bit width.
  function automatic sel_t next_rr(input sel_t ptr);
    return ptr + sel_t'(1);
  endfunction

endpackage

// File: rtl/stream_demux_1_4_out_slot.sv
// One-entry output buffer for a single demux slot.
// A load wins over a drain, so a simultaneous drain and load keeps the slot full.
module out_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] data
);

  // Data is left untouched on a drain; only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on every port.
// The target slot comes from sel or from an internal round-robin pointer.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       d,
  input  logic [1:0]         sel,
  input  logic               rr_en,
  output logic [N_OUT-1:0]   out_valid,
  output logic [N_OUT*W-1:0] out_data,
  input  logic [N_OUT-1:0]   out_ready
);

  sel_t             rr_ptr;
  sel_t             eff_sel;
  logic             accept;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] drain;

  // A full target slot can still accept when its consumer drains in the same cycle.
  assign eff_sel  = rr_en ? rr_ptr : sel;
  assign in_ready = !out_valid[eff_sel] || out_ready[eff_sel];
  assign accept   = in_valid && in_ready;

  // The pointer never skips a blocked slot; it only advances on an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && rr_en) begin
      rr_ptr <= next_rr(rr_ptr);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k]  = accept && (eff_sel == sel_t'(k));
    assign drain[k] = out_valid[k] && out_ready[k];

    out_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .drain (drain[k]),
      .d     (d),
      .valid (out_valid[k]),
      .data  (out_data[k*W +: W])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4 with hand-computed expectations.
// Inputs change #1 after the rising edge and outputs are sampled there too.
module tb_stream_demux_1_4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  d;
  logic [1:0]  sel;
  logic        rr_en;
  logic [3:0]  out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_ready;

  int checkCount = 0;
  int failCount  = 0;

  stream_demux_1_4 #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .sel       (sel),
    .rr_en     (rr_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] dd, input logic [1:0] s,
                               input logic rr, input logic [3:0] ordy);
    in_valid  = v;
    d         = dd;
    sel       = s;
    rr_en     = rr;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 2'd0, 1'b0, 4'b0000);

    // Reset held two cycles
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_data", 32'(out_data), 32'h0);
    checkOutput("reset_ready", 32'(in_ready), 32'h1);
    checkOutput("reset_ptr", 32'(dut.rr_ptr), 32'h0);

    // Idle input with X data leaves everything unchanged
    in_valid = 1'b0;
    d   = 'x;
    sel = 'x;
    tick();
    checkOutput("idle_valid", 32'(out_valid), 32'h0);
    checkOutput("idle_data", 32'(out_data), 32'h0);

    // Directed fill of all four slots
    applyStimulus(1'b1, 4'hA, 2'd0, 1'b0, 4'b0000);
    checkOutput("fill0_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("fill0_valid", 32'(out_valid), 32'h1);
    applyStimulus(1'b1, 4'hB, 2'd1, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b1, 4'hC, 2'd2, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b1, 4'hD, 2'd3, 1'b0, 4'b0000);
    checkOutput("fill3_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("fill_valid", 32'(out_valid), 32'hF);
    checkOutput("fill_data", 32'(out_data), 32'hDCBA);

    // Full slot without consumer blocks the input
    applyStimulus(1'b1, 4'hE, 2'd2, 1'b0, 4'b0000);
    checkOutput("blocked_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("blocked_data", 32'(out_data), 32'hDCBA);
    checkOutput("blocked_valid", 32'(out_valid), 32'hF);

    // Pass-through: slot 1 gets 7, then 3 with a simultaneous drain
    applyStimulus(1'b1, 4'h7, 2'd1, 1'b0, 4'b0010);
    tick();
    checkOutput("pt_setup_data", 32'(out_data), 32'hDC7A);
    applyStimulus(1'b1, 4'h3, 2'd1, 1'b0, 4'b0010);
    checkOutput("pt_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("pt_valid", 32'(out_valid), 32'hF);
    checkOutput("pt_data", 32'(out_data), 32'hDC3A);

    // Drain only: valid drops, data holds
    applyStimulus(1'b0, 4'h0, 2'd0, 1'b0, 4'b1000);
    tick();
    checkOutput("drain_valid", 32'(out_valid), 32'h7);
    checkOutput("drain_data", 32'(out_data), 32'hDC3A);

    // Round-robin with sel held at 3 and all consumers ready
    applyStimulus(1'b1, 4'h1, 2'd3, 1'b1, 4'b1111);
    tick();
    checkOutput("rr1_valid", 32'(out_valid), 32'h1);
    checkOutput("rr1_data", 32'(out_data), 32'hDC31);
    applyStimulus(1'b1, 4'h2, 2'd3, 1'b1, 4'b1111);
    tick();
    checkOutput("rr2_data", 32'(out_data), 32'hDC21);
    applyStimulus(1'b1, 4'h3, 2'd3, 1'b1, 4'b1111);
    tick();
    checkOutput("rr3_data", 32'(out_data), 32'hD321);
    applyStimulus(1'b1, 4'h4, 2'd3, 1'b1, 4'b1111);
    tick();
    checkOutput("rr4_valid", 32'(out_valid), 32'h8);
    checkOutput("rr4_data", 32'(out_data), 32'h4321);
    applyStimulus(1'b1, 4'h5, 2'd3, 1'b1, 4'b1111);
    tick();
    checkOutput("rr5_valid", 32'(out_valid), 32'h1);
    checkOutput("rr5_data", 32'(out_data), 32'h4325);
    checkOutput("rr5_ptr", 32'(dut.rr_ptr), 32'h1);

    // Round-robin backpressure: fill slot 1 directly, then rr waits on it
    applyStimulus(1'b1, 4'h6, 2'd1, 1'b0, 4'b0000);
    tick();
    checkOutput("bp_setup_valid", 32'(out_valid), 32'h3);
    checkOutput("bp_setup_ptr", 32'(dut.rr_ptr), 32'h1);
    applyStimulus(1'b1, 4'h8, 2'd0, 1'b1, 4'b0000);
    checkOutput("bp_ready_low", 32'(in_ready), 32'h0);
    tick();
    checkOutput("bp_ptr_hold", 32'(dut.rr_ptr), 32'h1);
    checkOutput("bp_data_hold", 32'(out_data), 32'h4365);
    applyStimulus(1'b1, 4'h8, 2'd0, 1'b1, 4'b0010);
    checkOutput("bp_ready_high", 32'(in_ready), 32'h1);
    tick();
    checkOutput("bp_ptr_adv", 32'(dut.rr_ptr), 32'h2);
    checkOutput("bp_data", 32'(out_data), 32'h4385);
    checkOutput("bp_valid", 32'(out_valid), 32'h3);

    // Fill slots 2 and 3, then reset mid-operation
    applyStimulus(1'b1, 4'h9, 2'd2, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b1, 4'hA, 2'd3, 1'b0, 4'b0000);
    tick();
    checkOutput("pre_rst_valid", 32'(out_valid), 32'hF);
    checkOutput("pre_rst_data", 32'(out_data), 32'hA985);
    applyStimulus(1'b0, 4'h0, 2'd0, 1'b0, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_data", 32'(out_data), 32'h0);
    checkOutput("mid_rst_ptr", 32'(dut.rr_ptr), 32'h0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'h1);

    // First rr accept after reset lands in slot 0
    applyStimulus(1'b1, 4'hC, 2'd3, 1'b1, 4'b0000);
    tick();
    checkOutput("post_rst_valid", 32'(out_valid), 32'h1);
    checkOutput("post_rst_data", 32'(out_data), 32'h000C);
    checkOutput("post_rst_ptr", 32'(dut.rr_ptr), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
